main_memory_arbiter: RTL
========================

# main_memory_arbiter

Two-port round-robin arbiter and access sequencer for the main memory block. It accepts read or write requests from two independent requesters (port 0, port 1), grants one at a time, and drives the memory's `rd_mem`/`wr_mem`/`addr_mem`/`data_in` strobes for a fixed access window. It then captures read data and returns a one-cycle `done` pulse to the winner. It sits between the CPU-side and DMA-side masters and the single-port memory, which acts on the falling clock edge.

## Interface
- `AWIDTH`, 9: address width, matching the memory.
- `DWIDTH`, 8: data width, matching the memory.
- `ACC_CYCLES`, 2: clock cycles the strobe is held per access; legal range 1..15.

- `clk` in 1: single clock, rising edge for all arbiter state.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request, level.
- `we0` / `we1` in 1: 1 means write, 0 means read; sampled at grant.
- `addr0` / `addr1` in AWIDTH: access address; sampled at grant.
- `wdata0` / `wdata1` in DWIDTH: write data; sampled at grant.
- `done0` / `done1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out DWIDTH: read result; holds until that port's next read completes.
- `busy` out 1: high in ACCESS and RECOVER.
- `rd_mem` out 1: memory read strobe.
- `wr_mem` out 1: memory write strobe.
- `addr_mem` out AWIDTH: memory address.
- `data_in` out DWIDTH: memory write data.
- `ready_mem` in 1: memory ready (low while a strobe is high).
- `mem_rdata` in DWIDTH: connects to the memory `data_out`.

## Operation
- Reset (async assert) drives all of the following:
  - state IDLE
  - `rd_mem`=0, `wr_mem`=0, `addr_mem`=0, `data_in`=0
  - `done0`/`done1`=0, `rdata0`/`rdata1`=0, `busy`=0
  - last-grant pointer=1, so port 0 wins the first tie.
- Reset mid-ACCESS or mid-RECOVER has these effects:
  - The transaction is abandoned and no `done` is issued.
  - Strobes drop asynchronously.
  - Requesters must re-request after reset.
- State machine, IDLE → ACCESS → RECOVER → IDLE:
  - **IDLE:** at a rising edge with any `req` high, pick the winner.
    - Only one request high: that port wins.
    - Both high: the port that is not the last-grant pointer wins.
    - On grant, latch the winner's `we`/`addr`/`wdata` into `addr_mem`/`data_in`, set `rd_mem`=~we or `wr_mem`=we, set the pointer to the winner, load cnt=ACC_CYCLES-1 and go to ACCESS.
  - **ACCESS:** hold the strobe, address and data stable.
    - At each rising edge with cnt≠0, decrement cnt.
    - At the edge with cnt=0:
      - If the access is a read, capture `mem_rdata` into `rdataN`.
      - Drop the strobe, raise `doneN` and go to RECOVER.
  - **RECOVER:** `doneN` is high for exactly this cycle.
    - At the next edge, if `ready_mem`=1: clear `done`, go to IDLE.
    - If `ready_mem`=0, stay in RECOVER with `done` cleared after the first cycle; this is a memory fault.
- Write ordering: `rd_mem` and `wr_mem` are never high together. Only the granted port's `rdata` changes, and only on a read.
- Requester rule: drop `reqN` on the edge that ends the `doneN` cycle. A `req` still high in IDLE is treated as a new request.
- `addr`, `we` and `wdata` are don't-care after grant.
- A request arriving during ACCESS or RECOVER waits; it is never lost while held.
- Fairness: with both ports continuously requesting, grants strictly alternate.

## Timing
- Grant edge E0: strobe is high from E0 to E0+ACC_CYCLES, which covers ACC_CYCLES falling edges where the memory acts.
- Read data comes from the memory's falling-edge register. It is valid at E0+ACC_CYCLES and `rdataN` updates at that edge.
- `doneN` is high from E0+ACC_CYCLES to E0+ACC_CYCLES+1.
- The earliest next grant is at edge E0+ACC_CYCLES+2.
- Throughput is one access per ACC_CYCLES+2 cycles; with the default, one access per 4 cycles.
- All outputs are registered; none is combinational from requester inputs.
- `busy` equals (state≠IDLE).

## Test plan
- Single port-0 write then read:
  - Stimulus: write `8'hA5` to address 9'h010, then read 9'h010.
  - Write: `wr_mem` high for 2 cycles and `done0` 1 cycle.
  - Read: `rdata0`=A5, with `done0` at E0+2.
- Simultaneous requests after reset:
  - Stimulus: `req0`=`req1`=1, both reads, with port 1 reading address 9'h1FF preloaded with 8'h3C.
  - Port 0 is served first, then port 1 at grant edge +4, with `rdata1`=3C.
  - Continued holding of both requests gives alternating grants 0,1,0,1.
- Port 1 continuous with port 0 arriving mid-ACCESS:
  - Port 0 is granted at the very next IDLE edge, ahead of port 1's next request.
- Back-to-back port-0 accesses with port 1 idle:
  - Grants occur every 4 cycles.
  - `rdata1` is unchanged (stays 0).
- `reset_n` low for 1 cycle during ACCESS of a write:
  - Strobes drop immediately and no `done` is issued.
  - All outputs are at reset values.
  - After release, a new request completes normally.
- `ACC_CYCLES`=1 build:
  - Strobe lasts 1 cycle, `done` comes at E0+1, and the next grant is at E0+3.
  - Write/read of address 9'h0AA with data 8'h5A returns 5A.

Source files
------------

// File: rtl/main_memory_arbiter.sv
// Two-port round-robin arbiter and fixed-window access sequencer
// for the single-port main memory.
module main_memory_arbiter #(
  parameter int unsigned AWIDTH     = 9,
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              busy,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] data_in,
  input  logic              ready_mem,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last;
  logic          cur;
  logic          win;
  logic          any_req;
  logic [CW-1:0] cnt;

  assign any_req = req0 | req1;
  assign busy    = (state != IDLE);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 & ~req1): win = 1'b0;
      (~req0 & req1): win = 1'b1;
      default:        win = ~last;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = RECOVER;
      RECOVER: if (ready_mem) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last     <= 1'b1;
      cur      <= 1'b0;
      cnt      <= '0;
      rd_mem   <= 1'b0;
      wr_mem   <= 1'b0;
      addr_mem <= '0;
      data_in  <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last     <= win;
            cur      <= win;
            addr_mem <= win ? addr1 : addr0;
            data_in  <= win ? wdata1 : wdata0;
            rd_mem   <= win ? ~we1 : ~we0;
            wr_mem   <= win ? we1 : we0;
            cnt      <= CW'(ACC_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (rd_mem && !cur) rdata0 <= mem_rdata;
            if (rd_mem && cur)  rdata1 <= mem_rdata;
            rd_mem <= 1'b0;
            wr_mem <= 1'b0;
            done0  <= ~cur;
            done1  <= cur;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
